tiny_cpu: RTL and testbench
===========================

Name: tiny_cpu

Overview:
- Minimal single-cycle, memory-to-memory processor with a 3-bit PC and an 8-word × 9-bit unified instruction/data memory.
- Every instruction is fetched and executed in one clock cycle.
- Reset reloads a fixed program image into memory.
- Benches inspect memory through the hierarchical instance MEM, array mem[0:7].

Parameters:
- None. Widths are fixed by the ISA: 9-bit word, 3-bit address.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- pc  output  3  current program counter, the address of the instruction being executed

Behaviour:
- Instruction format: op = word[8:6], x = word[5:3], y = word[2:0]. x and y are memory addresses.
- Reset (reset low, asynchronous):
  - pc = 0.
  - mem[0..7] = 100101010, 110111000, 110111010, 000000000, 000000001, 000000101, 000000000, 111001111.
  - The image is held for as long as reset stays low.
- Memory:
  - Three combinational read ports: fetch mem[pc], operand mem[x], operand mem[y].
  - One synchronous write port: mem[y].
  - Fetch and operand reads see pre-edge contents.
- Per rising clk edge (reset high), execute word = mem[pc]:
  - 000 NOP: pc+1.
  - 001 SUB: mem[y] = mem[y] − mem[x]; pc+1.
  - 010 AND: mem[y] = mem[y] & mem[x]; pc+1.
  - 011 OR: mem[y] = mem[y] | mem[x]; pc+1.
  - 100 MOV: mem[y] = mem[x]; pc+1.
  - 101 BEQZ: if mem[x] == 0 then pc = y, else pc+1; no write.
  - 110 ADD: mem[y] = mem[y] + mem[x]; pc+1.
  - 111 JMP: pc = y; x ignored; no write.
- Arithmetic is 9-bit modulo 512. There are no flags and no carry out.
- pc+1 wraps from 7 to 0.
- Self-modification is legal:
  - A write to mem[pc] takes effect at the next fetch.
  - If x == y, both operands read the same pre-edge value.
- JMP to its own address (e.g. 111xxx111 at address 7) is the halt idiom. pc and memory then stay constant.
- Reset asserted mid-execution: pc and memory return to the image immediately, with no clock required. Release takes effect at the next rising edge, which executes mem[0].

Optional Feature:
- Macro TINY_CPU_HALT_EN.
- Defined:
  - Adds output port halted (1 bit).
  - halted is combinationally 1 when the fetched word is JMP with y == pc.
  - halted resets to 0 via pc = 0 and the image.
  - While halted is 1, all memory writes are gated off.
- Undefined:
  - No halted port.
  - Self-jump simply loops, with identical observable state.

Decomposition:
- Package tiny_cpu_pkg holds:
  - Constants WORD_W = 9, ADDR_W = 3, DEPTH = 8.
  - Opcode enum: OP_NOP, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_BEQZ, OP_ADD, OP_JMP.
  - Reset image constant array INIT_IMAGE.
- One sub-module, tiny_cpu_mem, instantiated as MEM:
  - Flop array mem[0:7].
  - Asynchronous load of INIT_IMAGE.
  - Three combinational read ports and one write port with write enable.
- The top holds the pc register and a combinational ALU/decode.

Test Plan:
- Hold reset low for 1 clock:
  - mem[0..7] equals the image exactly.
  - pc == 0.
  - Release reset and check at the next sample that pc == 0 before the first execute edge.
- Release reset, then step 1 clock:
  - MOV 5→2 gives mem[2] == 000000101.
  - pc == 1.
- Next clock:
  - ADD mem[0] += mem[7] gives mem[0] == 011111001 (0x12A + 0x1CF mod 512).
  - pc == 2.
- Next 5 clocks:
  - Words at addresses 2–6 execute as NOPs (mem[2] now has op 000).
  - pc reaches 7.
  - No other memory changes.
- Run 70 further clocks:
  - pc stays 7.
  - Final memory is mem[0] = 011111001, mem[2] = 000000101, all other words equal to the image.
  - With TINY_CPU_HALT_EN, halted == 1.
- Assert reset asynchronously mid-run (between edges):
  - pc = 0 and the image are restored immediately.
- Force-load mem[3] = 101100110 (BEQZ x=4, y=6) while mem[4] = 0 and pc = 3:
  - Next pc == 6.
  - With mem[4] = 1, next pc == 4.

Source files
------------

// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: ISA widths, opcode encoding and the reset program image.
// Pure declarations; no latency or backpressure.
package tiny_cpu_pkg;
  localparam int WORD_W = 9;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_MOV  = 3'd4,
    OP_BEQZ = 3'd5,
    OP_ADD  = 3'd6,
    OP_JMP  = 3'd7
  } op_t;

  localparam logic [WORD_W-1:0] INIT_IMAGE [DEPTH] = '{
    9'b100101010, 9'b110111000, 9'b110111010, 9'b000000000,
    9'b000000001, 9'b000000101, 9'b000000000, 9'b111001111
  };

  function automatic op_t word_op(input logic [WORD_W-1:0] w);
    return op_t'(w[8:6]);
  endfunction
endpackage

// File: rtl/tiny_cpu_mem.sv
// tiny_cpu_mem: 8x9 flop memory, three combinational reads, one write at clk edge.
// Reads are zero latency; no backpressure; image reloaded while reset is low.
module tiny_cpu_mem
  import tiny_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [WORD_W-1:0] fetch_dat,
  input  logic [ADDR_W-1:0] x_addr,
  output logic [WORD_W-1:0] x_dat,
  input  logic [ADDR_W-1:0] y_addr,
  output logic [WORD_W-1:0] y_dat,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_dat
);
  logic [WORD_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_IMAGE[i];
    end else if (wr_en) begin
      mem[y_addr] <= wr_dat;
    end
  end

  assign fetch_dat = mem[fetch_addr];
  assign x_dat     = mem[x_addr];
  assign y_dat     = mem[y_addr];
endmodule

// File: rtl/tiny_cpu.sv
// tiny_cpu: single-cycle memory-to-memory CPU, one instruction retired per clk edge.
// No backpressure; TINY_CPU_HALT_EN adds a halted output that gates memory writes.
module tiny_cpu
  import tiny_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] pc
`ifdef TINY_CPU_HALT_EN
  ,
  output logic              halted
`endif
);
  logic [WORD_W-1:0] ir, xv, yv, res;
  logic [ADDR_W-1:0] xa, ya, pc_nxt;
  logic              we, wr_en;
  op_t               op;

  assign op = word_op(ir);
  assign xa = ir[5:3];
  assign ya = ir[2:0];

  tiny_cpu_mem MEM (
    .clk        (clk),
    .reset      (reset),
    .fetch_addr (pc),
    .fetch_dat  (ir),
    .x_addr     (xa),
    .x_dat      (xv),
    .y_addr     (ya),
    .y_dat      (yv),
    .wr_en      (wr_en),
    .wr_dat     (res)
  );

  always_comb begin
    res    = yv;
    we     = 1'b0;
    pc_nxt = pc + 3'd1;
    case (op)
      OP_SUB:  begin res = yv - xv; we = 1'b1; end
      OP_AND:  begin res = yv & xv; we = 1'b1; end
      OP_OR:   begin res = yv | xv; we = 1'b1; end
      OP_MOV:  begin res = xv;      we = 1'b1; end
      OP_ADD:  begin res = yv + xv; we = 1'b1; end
      OP_BEQZ: if (xv == '0) pc_nxt = ya;
      OP_JMP:  pc_nxt = ya;
      default: ;
    endcase
  end

`ifdef TINY_CPU_HALT_EN
  assign halted = (op == OP_JMP) && (ya == pc);
  assign wr_en  = we && !halted;
`else
  assign wr_en  = we;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_nxt;
  end
endmodule

// File: tb/tb_tiny_cpu.sv
// tb_tiny_cpu: directed program checks plus random programs against a behavioural model.
// Define TINY_CPU_HALT_EN to also check the halted output.
module tb_tiny_cpu;
  logic       clk;
  logic       reset;
  logic [2:0] pc;
`ifdef TINY_CPU_HALT_EN
  logic       halted;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] IMG [8] = '{
    9'b100101010, 9'b110111000, 9'b110111010, 9'b000000000,
    9'b000000001, 9'b000000101, 9'b000000000, 9'b111001111
  };

  logic [8:0] m [8];
  logic [2:0] mpc;

  tiny_cpu dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc)
`ifdef TINY_CPU_HALT_EN
    ,
    .halted(halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference semantics: one instruction per call, arithmetic done in int mod 512.
  task automatic model_step();
    int w, op, x, y, a, b, npc;
    w   = int'(m[mpc]);
    op  = w / 64;
    x   = (w / 8) % 8;
    y   = w % 8;
    a   = int'(m[x]);
    b   = int'(m[y]);
    npc = (int'(mpc) + 1) % 8;
    case (op)
      1: m[y] = 9'((b - a + 512) % 512);
      2: m[y] = 9'(a & b);
      3: m[y] = 9'(a | b);
      4: m[y] = 9'(a);
      5: if (a == 0) npc = y;
      6: m[y] = 9'((a + b) % 512);
      7: npc = y;
      default: ;
    endcase
    mpc = 3'(npc);
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.MEM.mem[i] !== m[i]) begin
        errors++;
        $display("FAIL %s mem[%0d] got %b want %b", name, i, dut.MEM.mem[i], m[i]);
      end
    end
  endtask

  task automatic check_pc(input string name, input logic [2:0] want);
    checks++;
    if (pc !== want) begin
      errors++;
      $display("FAIL %s pc got %0d want %0d", name, pc, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) m[i] = IMG[i];
    check_mem("reset_image");
    check_pc("reset_pc", 3'd0);
    reset = 1'b1;
    #1;
    check_pc("release_pc", 3'd0);
  endtask

  task automatic test_program();
    @(negedge clk);
    checks++;
    if (dut.MEM.mem[2] !== 9'b000000101) begin
      errors++;
      $display("FAIL mov mem[2] got %b want %b", dut.MEM.mem[2], 9'b000000101);
    end
    check_pc("mov_pc", 3'd1);
    @(negedge clk);
    checks++;
    if (dut.MEM.mem[0] !== 9'b011111001) begin
      errors++;
      $display("FAIL add mem[0] got %b want %b", dut.MEM.mem[0], 9'b011111001);
    end
    check_pc("add_pc", 3'd2);
    for (int i = 0; i < 8; i++) m[i] = IMG[i];
    m[0] = 9'b011111001;
    m[2] = 9'b000000101;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_pc("nop_pc", 3'(3 + s));
    end
    check_mem("nop_mem");
    for (int s = 0; s < 70; s++) begin
      @(negedge clk);
      check_pc("halt_pc", 3'd7);
    end
    check_mem("halt_mem");
`ifdef TINY_CPU_HALT_EN
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halted got %b want 1", halted);
    end
`endif
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m[i] = IMG[i];
    check_pc("async_pc", 3'd0);
    check_mem("async_mem");
`ifdef TINY_CPU_HALT_EN
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL async_halted got %b want 0", halted);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_beqz(input logic [8:0] m4, input logic [2:0] want);
    do_reset();
    repeat (3) @(negedge clk);
    check_pc("beqz_setup_pc", 3'd3);
    dut.MEM.mem[3] = 9'b101100110;
    dut.MEM.mem[4] = m4;
    @(negedge clk);
    check_pc("beqz_pc", want);
  endtask

  task automatic test_random();
    logic [8:0] w;
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        w = 9'($urandom_range(0, 511));
        dut.MEM.mem[i] = w;
        m[i] = w;
      end
      mpc = 3'd0;
      for (int s = 0; s < 16; s++) begin
`ifdef TINY_CPU_HALT_EN
        checks++;
        if (halted !== ((m[mpc][8:6] == 3'd7) && (m[mpc][2:0] == mpc))) begin
          errors++;
          $display("FAIL rand_halted got %b at pc %0d", halted, mpc);
        end
`endif
        @(negedge clk);
        model_step();
        check_pc("rand_pc", mpc);
        check_mem("rand_mem");
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_program();
    test_async_reset();
    test_beqz(9'd0, 3'd6);
    test_beqz(9'd1, 3'd4);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
